// File: rtl/fir_host_master_if.sv
// fir_host_master_if
//   Bus bundle between the host-side fir master and its neighbours.
//   AXI-Lite write (aw/w, no B channel) and read (ar/r) channels,
//   ss_* stream into the accelerator, sm_* stream out of it,
//   src_* upstream sample source, dst_* downstream result sink.
//   modport master : the fir_host_master side
//   modport slave  : accelerator / source / sink side
interface fir_host_master_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;

    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;

    logic                   ss_tvalid;
    logic                   ss_tready;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tlast;

    logic                   sm_tvalid;
    logic                   sm_tready;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   sm_tlast;

    logic                   src_tvalid;
    logic                   src_tready;
    logic [pDATA_WIDTH-1:0] src_tdata;

    logic                   dst_tvalid;
    logic                   dst_tready;
    logic [pDATA_WIDTH-1:0] dst_tdata;
    logic                   dst_tlast;

    modport master (
        output awvalid, awaddr, wvalid, wdata,
        input  awready, wready,
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata,
        output ss_tvalid, ss_tdata, ss_tlast,
        input  ss_tready,
        input  sm_tvalid, sm_tdata, sm_tlast,
        output sm_tready,
        input  src_tvalid, src_tdata,
        output src_tready,
        output dst_tvalid, dst_tdata, dst_tlast,
        input  dst_tready
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata,
        output awready, wready,
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata,
        input  ss_tvalid, ss_tdata, ss_tlast,
        output ss_tready,
        output sm_tvalid, sm_tdata, sm_tlast,
        input  sm_tready,
        output src_tvalid, src_tdata,
        input  src_tready,
        input  dst_tvalid, dst_tdata, dst_tlast,
        output dst_tready
    );
endinterface

// File: rtl/fir_host_master.sv
// fir_host_master
//   Host-side driver for the fir accelerator. Keeps a local tap array
//   (loaded through cfg_*), and on start programs the accelerator over
//   AXI-Lite (data_length, taps, ap_start), streams data_len samples
//   from src to the accelerator, forwards its results to dst, then
//   polls ap_ctrl until ap_done and pulses done.
//
//   Ports:
//     axis_clk, axis_rst_n   clock, asynchronous active-low reset
//     start, data_len        launch request, sample count (latched on start)
//     cfg_we/idx/data        tap array write port (ignored while busy)
//     busy, done             running flag, one-cycle completion pulse
//     err[2:0]               sticky: 0 tlast mismatch, 1 poll timeout,
//                            2 tap readback mismatch
//     bus                    fir_host_master_if.master (AXI-Lite + streams)
//
//   Optional: define FIR_HOST_READBACK_EN to read every tap back after
//   programming and flag mismatches in err[2].
//
//   Register map: 0x00 ap_ctrl, 0x10 data_length, 0x20+4*i tap i.
module fir_host_master #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11,
    parameter int pLEN_WIDTH  = 10,
    parameter int POLL_MAX    = 1024
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   start,
    input  logic [pLEN_WIDTH-1:0]  data_len,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_idx,
    input  logic [pDATA_WIDTH-1:0] cfg_data,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             err,
    fir_host_master_if.master      bus
);

    localparam int CNT_W  = pLEN_WIDTH + 1;
    localparam int TAP_W  = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
    localparam int POLL_W = $clog2(POLL_MAX + 1);

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);

    typedef enum logic [3:0] {
        IDLE,
        WR_LEN,
        WR_TAP,
`ifdef FIR_HOST_READBACK_EN
        RB_AR,
        RB_R,
`endif
        WR_START,
        STREAM,
        POLL_AR,
        POLL_R,
        FINISH
    } state_t;

    state_t                   state;
    logic [pDATA_WIDTH-1:0]   taps [Tape_Num];
    logic [pLEN_WIDTH-1:0]    len;
    logic [CNT_W-1:0]         in_cnt;
    logic [CNT_W-1:0]         out_cnt;
    logic [TAP_W-1:0]         tap_idx;
    logic [POLL_W-1:0]        poll_cnt;
    logic                     wr_active;

    logic                     awvalid_q;
    logic                     wvalid_q;
    logic [pADDR_WIDTH-1:0]   awaddr_q;
    logic [pDATA_WIDTH-1:0]   wdata_q;
    logic                     arvalid_q;
    logic                     rready_q;
    logic [pADDR_WIDTH-1:0]   araddr_q;

    function automatic logic [pADDR_WIDTH-1:0] tap_addr(input logic [TAP_W-1:0] i);
        return pADDR_WIDTH'(32'h20 + 32'(i) * 32'd4);
    endfunction

    // ------------------------------------------------------------------
    // Stream paths: combinational pass-through, gated by STREAM and the
    // remaining-beat counters.
    // ------------------------------------------------------------------
    logic             in_stream;
    logic [CNT_W-1:0] len_ext;
    logic             in_more;
    logic             out_more;
    logic             ss_hs;
    logic             sm_hs;
    logic             aw_hs;
    logic             w_hs;
    logic             wr_done;
    logic             last_tap;

    assign in_stream = (state == STREAM);
    assign len_ext   = CNT_W'(len);
    assign in_more   = (in_cnt  < len_ext);
    assign out_more  = (out_cnt < len_ext);

    assign bus.ss_tvalid  = in_stream && bus.src_tvalid && in_more;
    assign bus.src_tready = in_stream && bus.ss_tready  && in_more;
    assign bus.ss_tdata   = bus.src_tdata;
    assign bus.ss_tlast   = in_stream && (in_cnt == len_ext - 1'b1);

    assign bus.sm_tready  = in_stream && bus.dst_tready && out_more;
    assign bus.dst_tvalid = in_stream && bus.sm_tvalid  && out_more;
    assign bus.dst_tdata  = bus.sm_tdata;
    assign bus.dst_tlast  = in_stream && (out_cnt == len_ext - 1'b1);

    assign ss_hs = bus.ss_tvalid && bus.ss_tready;
    assign sm_hs = bus.sm_tvalid && bus.sm_tready;

    assign bus.awvalid = awvalid_q;
    assign bus.awaddr  = awaddr_q;
    assign bus.wvalid  = wvalid_q;
    assign bus.wdata   = wdata_q;
    assign bus.arvalid = arvalid_q;
    assign bus.araddr  = araddr_q;
    assign bus.rready  = rready_q;

    // A write is finished once each channel has either already
    // handshaken (valid dropped) or is handshaking this cycle.
    assign aw_hs    = awvalid_q && bus.awready;
    assign w_hs     = wvalid_q  && bus.wready;
    assign wr_done  = wr_active && (!awvalid_q || bus.awready) && (!wvalid_q || bus.wready);
    assign last_tap = (tap_idx == TAP_W'(Tape_Num - 1));

    // ------------------------------------------------------------------
    // Local tap array
    // ------------------------------------------------------------------
    always_ff @(posedge axis_clk) begin
        if (cfg_we && !busy && (32'(cfg_idx) < Tape_Num))
            taps[TAP_W'(cfg_idx)] <= cfg_data;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state     <= IDLE;
            len       <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            tap_idx   <= '0;
            poll_cnt  <= '0;
            wr_active <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= '0;
        end else begin
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        len     <= data_len;
                        err     <= '0;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= WR_LEN;
                    end
                end

                WR_LEN: begin
                    if (!wr_active) begin
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        awaddr_q  <= ADDR_LEN;
                        wdata_q   <= pDATA_WIDTH'(len);
                        wr_active <= 1'b1;
                    end else if (wr_done) begin
                        wr_active <= 1'b0;
                        tap_idx   <= '0;
                        state     <= WR_TAP;
                    end
                end

                WR_TAP: begin
                    if (!wr_active) begin
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        awaddr_q  <= tap_addr(tap_idx);
                        wdata_q   <= taps[tap_idx];
                        wr_active <= 1'b1;
                    end else if (wr_done) begin
                        wr_active <= 1'b0;
                        if (last_tap) begin
                            tap_idx <= '0;
`ifdef FIR_HOST_READBACK_EN
                            state   <= RB_AR;
`else
                            state   <= WR_START;
`endif
                        end else begin
                            tap_idx <= tap_idx + 1'b1;
                        end
                    end
                end

`ifdef FIR_HOST_READBACK_EN
                RB_AR: begin
                    if (!arvalid_q) begin
                        arvalid_q <= 1'b1;
                        araddr_q  <= tap_addr(tap_idx);
                    end else if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RB_R;
                    end
                end

                RB_R: begin
                    if (bus.rvalid) begin
                        rready_q <= 1'b0;
                        if (bus.rdata != taps[tap_idx])
                            err[2] <= 1'b1;
                        if (last_tap) begin
                            state <= WR_START;
                        end else begin
                            tap_idx <= tap_idx + 1'b1;
                            state   <= RB_AR;
                        end
                    end
                end
`endif

                WR_START: begin
                    if (!wr_active) begin
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        awaddr_q  <= ADDR_CTRL;
                        wdata_q   <= pDATA_WIDTH'(1);
                        wr_active <= 1'b1;
                    end else if (wr_done) begin
                        wr_active <= 1'b0;
                        state     <= STREAM;
                    end
                end

                STREAM: begin
                    if (ss_hs)
                        in_cnt <= in_cnt + 1'b1;
                    if (sm_hs) begin
                        out_cnt <= out_cnt + 1'b1;
                        if (bus.sm_tlast != (out_cnt == len_ext - 1'b1))
                            err[0] <= 1'b1;
                    end
                    // Counters are compared before this cycle's handshakes,
                    // so len=0 leaves immediately.
                    if (!in_more && !out_more) begin
                        poll_cnt <= '0;
                        state    <= POLL_AR;
                    end
                end

                POLL_AR: begin
                    if (!arvalid_q) begin
                        arvalid_q <= 1'b1;
                        araddr_q  <= ADDR_CTRL;
                    end else if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= POLL_R;
                    end
                end

                POLL_R: begin
                    if (bus.rvalid) begin
                        rready_q <= 1'b0;
                        if (bus.rdata[1]) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else if (poll_cnt == POLL_W'(POLL_MAX - 1)) begin
                            poll_cnt <= POLL_W'(POLL_MAX);
                            err[1]   <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                            state    <= POLL_AR;
                        end
                    end
                end

                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fir_host_master.md
Name: fir_host_master

Overview:
- AXI-Lite master plus AXI-Stream source/sink that drives the fir accelerator from the host side.
- Holds a local tap array loaded from a config port; on `start` it programs the accelerator over AXI-Lite: `data_length`, taps, then `ap_start`.
- Streams `data_len` samples from an upstream source into the accelerator and forwards its results to a downstream sink.
- Polls `ap_ctrl` until `ap_done`, then pulses `done`.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width
- pDATA_WIDTH, 32, AXI-Lite/stream data width
- Tape_Num, 11, number of taps
- pLEN_WIDTH, 10, width of sample count
- POLL_MAX, 1024, max `ap_ctrl` reads before timeout

Ports:
- axis_clk  in  1  clock
- axis_rst_n  in  1  reset: asynchronous, active-low; clock is axis_clk
- start  in  1  one-cycle launch request
- data_len  in  pLEN_WIDTH  sample count, sampled on accepted start
- cfg_we  in  1  tap array write strobe
- cfg_idx  in  4  tap index
- cfg_data  in  pDATA_WIDTH  tap value
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  3  sticky: bit0 tlast mismatch, bit1 poll timeout, bit2 readback mismatch
- awvalid, awaddr, wvalid, wdata  out  1/pADDR_WIDTH/1/pDATA_WIDTH  AXI-Lite write master
- awready, wready  in  1  AXI-Lite write ready
- arvalid, araddr, rready  out  1/pADDR_WIDTH/1  AXI-Lite read master
- arready, rvalid  in  1  AXI-Lite read handshake
- rdata  in  pDATA_WIDTH  AXI-Lite read data
- ss_tvalid, ss_tdata, ss_tlast  out  1/pDATA_WIDTH/1  stream to accelerator
- ss_tready  in  1  accelerator stream-in ready
- sm_tvalid, sm_tdata, sm_tlast  in  1/pDATA_WIDTH/1  stream from accelerator
- sm_tready  out  1  accept from accelerator
- src_tvalid, src_tdata  in  1/pDATA_WIDTH  upstream samples
- src_tready  out  1  upstream ready
- dst_tvalid, dst_tdata, dst_tlast  out  1/pDATA_WIDTH/1  downstream results
- dst_tready  in  1  downstream ready

Behaviour:
- **Reset:** FSM=IDLE; all valid/ready/strobe outputs 0; addresses, wdata, err, counters 0. Reset mid-transfer drops all valids immediately (async).
- **Register map:** 0x00 ap_ctrl (bit0 ap_start, bit1 ap_done, bit2 ap_idle); 0x10 data_length; 0x20+4*i tap i.
- **Tap array:** written by `cfg_we` only when `busy`=0; `cfg_idx` >= Tape_Num is ignored.
- **FSM states:** IDLE, WR_LEN, WR_TAP, [RB_AR, RB_R], WR_START, STREAM, POLL_AR, POLL_R, FINISH.
- **IDLE:** `start` with `busy`=0 latches `data_len` and clears `err` -> WR_LEN. `start` while busy is ignored.
- **Write transaction:**
  - `awvalid` and `wvalid` are raised together with stable `awaddr`/`wdata`.
  - Each drops the cycle after its own handshake (valid&ready); the other is held until it completes independently.
  - The transaction is complete when both have handshaken. There is no B channel.
  - Next write issues at the earliest one cycle later.
- **Write sequence:**
  - WR_LEN writes 0x10 = `data_len`.
  - WR_TAP writes taps 0..Tape_Num-1 at 0x20+4*i.
  - WR_START writes 0x00 = 1 -> STREAM.
- **STREAM, input side:**
  - `ss_tvalid` = `src_tvalid` && in_cnt<len.
  - `src_tready` = `ss_tready` && in_cnt<len.
  - `ss_tdata` = `src_tdata` (combinational pass-through).
  - `ss_tlast` = (in_cnt==len-1).
  - in_cnt increments on each ss handshake.
- **STREAM, output side:**
  - `sm_tready` = `dst_tready` && out_cnt<len.
  - `dst_tvalid` = `sm_tvalid` && out_cnt<len.
  - `dst_tdata` = `sm_tdata`.
  - `dst_tlast` = (out_cnt==len-1).
  - out_cnt increments on each sm handshake.
  - If `sm_tlast` != (out_cnt==len-1) on a handshake, set `err`[0]; data is still forwarded.
- **STREAM exit:** when in_cnt==len and out_cnt==len -> POLL_AR. `len`=0 exits STREAM on its first cycle.
- **POLL_AR:** `arvalid`=1, `araddr`=0x00 until `arready`; then POLL_R.
- **POLL_R:**
  - `rready`=1 until `rvalid`.
  - If `rdata`[1] -> FINISH.
  - Otherwise poll_cnt++ and return to POLL_AR.
  - poll_cnt==POLL_MAX sets `err`[1] -> FINISH.
- **FINISH:** `done`=1 for exactly one cycle; `busy` drops the same cycle; next state IDLE.
- **Counters:** in_cnt and out_cnt are pLEN_WIDTH+1 bits, no wrap. poll_cnt saturates.
- **Simultaneous events:** in and out handshakes in the same cycle are both counted.

Optional Feature:
- Macro: `FIR_HOST_READBACK_EN`.
- **Defined:** after WR_TAP, the FSM reads each tap (RB_AR/RB_R, 0x20+4*i, same read handshake as polling) and compares it with the local array. Any mismatch sets `err`[2]. WR_START still executes.
- **Undefined:** WR_TAP goes directly to WR_START; `err`[2] stays 0.

Test Plan:
- Taps 0,-10,-9,23,56,63,56,23,-9,-10,0; len=4; slave `awready`/`wready` always 1 -> exactly 13 writes in order: 0x10=4, 0x20..0x48=taps, 0x00=1; `busy`=1 throughout.
- Slave `wready` lags `awready` by 3 cycles -> `awvalid` drops after its handshake, `wvalid` held 3 more cycles, `awaddr`/`wdata` stable; no duplicate writes.
- len=4, src samples 1,2,3,4, `sm_tlast` on the 4th output, `dst_tready` toggling 1/0 -> 4 outputs forwarded unchanged; `ss_tlast`/`dst_tlast` on the 4th beat only; `err`=0.
- Slave returns ap_ctrl = 0x4 for 5 reads, then 0x2 -> exactly 6 read transactions; `done` pulses once; `busy` is 0 the same cycle.
- POLL_MAX=8, `rdata` always 0x4 -> 8 reads; `err`[1]=1; `done` pulses; next `start` clears `err`.
- Assert `axis_rst_n`=0 during STREAM, then release -> all valids 0 immediately, FSM in IDLE; a new `start` replays the full write sequence from 0x10.
